// File: rtl/ps2_rx_ctrl.sv
// PS/2 keyboard receive controller: synchronises and deglitches the keyboard lines,
// frames the 11-bit device-to-host word and emits verified bytes as one-cycle valid pulses.
module ps2_rx_ctrl #(
    parameter int FILTER_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rx_en,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]    FLT_LAST = 8'(FILTER_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          ps2_clk_p0, ps2_clk_p1, ps2_clk_p2;
    logic          ps2_data_p0, ps2_data_p1;
    logic          flt_clk;
    logic [7:0]    flt_cnt;
    logic          fall;

    state_t        state, state_n;
    logic [7:0]    shreg, shreg_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic          parity_bit, parity_n;
    logic [TW-1:0] tmo_cnt, tmo_n;
    logic [7:0]    data_n;
    logic          valid_n, ferr_n;

    // Stage p0/p1: two-flop synchronisers; p2 keeps the previous synced clock for change detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps2_clk_p0  <= 1'b1;
            ps2_clk_p1  <= 1'b1;
            ps2_clk_p2  <= 1'b1;
            ps2_data_p0 <= 1'b1;
            ps2_data_p1 <= 1'b1;
        end else begin
            ps2_clk_p0  <= ps2_clk;
            ps2_clk_p1  <= ps2_clk_p0;
            ps2_clk_p2  <= ps2_clk_p1;
            ps2_data_p0 <= ps2_data;
            ps2_data_p1 <= ps2_data_p0;
        end
    end

    // Glitch filter: the synced clock must hold a new level steadily before flt_clk follows
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flt_clk <= 1'b1;
            flt_cnt <= 8'd0;
            fall    <= 1'b0;
        end else begin
            fall <= 1'b0;
            if ((ps2_clk_p1 == flt_clk) || (ps2_clk_p1 != ps2_clk_p2)) begin
                flt_cnt <= 8'd0;
            end else if (flt_cnt == FLT_LAST) begin
                flt_clk <= ps2_clk_p1;
                flt_cnt <= 8'd0;
                fall    <= ~ps2_clk_p1;
            end else begin
                flt_cnt <= flt_cnt + 8'd1;
            end
        end
    end

    // Frame sequencer state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= 8'd0;
            bit_cnt    <= 3'd0;
            parity_bit <= 1'b0;
            tmo_cnt    <= '0;
            data       <= 8'h00;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            bit_cnt    <= bit_cnt_n;
            parity_bit <= parity_n;
            tmo_cnt    <= tmo_n;
            data       <= data_n;
            valid      <= valid_n;
            frame_err  <= ferr_n;
        end
    end

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        parity_n  = parity_bit;
        data_n    = data;
        valid_n   = 1'b0;
        ferr_n    = 1'b0;
        tmo_n     = ((state == IDLE) || fall) ? '0 : tmo_cnt + TMO_ONE;

        unique case (state)
            IDLE: begin
                if (fall && !ps2_data_p1 && rx_en) begin
                    state_n   = DATA;
                    bit_cnt_n = 3'd0;
                end
            end
            DATA: begin
                if (fall) begin
                    shreg_n   = {ps2_data_p1, shreg[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_n = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    parity_n = ps2_data_p1;
                    state_n  = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    // Odd parity over data plus parity bit, and a high stop bit
                    if (ps2_data_p1 && (^{shreg, parity_bit})) begin
                        data_n  = shreg;
                        valid_n = 1'b1;
                    end else begin
                        ferr_n = 1'b1;
                    end
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // A stalled frame is aborted; a coincident fall takes priority
        if ((state != IDLE) && !fall && (tmo_cnt == TMO_LAST)) begin
            state_n = IDLE;
            ferr_n  = 1'b1;
            valid_n = 1'b0;
            tmo_n   = '0;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/ps2_rx_ctrl.md
Name: ps2_rx_ctrl

Overview:
PS/2 keyboard receive controller. It takes the raw keyboard clock and data lines, synchronises both, and filters glitches on the clock line. An FSM then sequences the 11-bit PS/2 device-to-host frame and hands each verified scan-code byte to downstream decode logic as a one-cycle valid pulse. Framing errors, parity errors and stalled frames are flagged and dropped.

Parameters:
FILTER_CYCLES, 16, consecutive clk cycles the synchronised ps2_clk must hold a new level before the filtered clock follows it (range 2..255)
TIMEOUT_CYCLES, 50000, maximum clk cycles between falling edges inside a frame before the frame is aborted (1 ms at 50 MHz)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous, active-low reset
ps2_clk  input  1  raw keyboard clock line, idle high
ps2_data  input  1  raw keyboard data line, idle high
rx_en  input  1  enables acceptance of new start bits
data  output  8  last correctly received byte
valid  output  1  one-cycle pulse: data updated this cycle
frame_err  output  1  one-cycle pulse: frame dropped (parity, stop or timeout)
busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset: asynchronous, active-low; clock clk. All synchroniser flops and the filtered clock reset to 1. Outputs reset to data=8'h00, valid=0, frame_err=0, busy=0. FSM resets to IDLE; shift register, bit counter, filter counter and timeout counter reset to 0.
- Synchronisation: ps2_clk and ps2_data each pass through a 2-FF synchroniser.
- Clock filter:
  - Counter clears whenever the synced clock equals the filtered clock or changes level; otherwise it increments.
  - The filtered clock takes the synced value when the counter reaches FILTER_CYCLES-1.
  - Any pulse shorter than FILTER_CYCLES cycles produces no edge.
- Edge strobe: fall=1 for exactly one cycle when the filtered clock goes 1->0. Data is sampled from the synced data line in the fall cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall with data=0 and rx_en=1 -> DATA, bit_cnt=0. A fall with data=1, or with rx_en=0, is ignored and the state stays IDLE.
  - DATA: on each fall, shift LSB-first (shreg={d,shreg[7:1]}) and increment bit_cnt. After the 8th bit (bit_cnt wraps 7->0) -> PARITY.
  - PARITY: on fall, capture the parity bit -> STOP.
  - STOP: on fall, check the frame.
    - Good if the stop bit is 1 and ^{shreg,parity}==1 (odd parity): data<=shreg, valid=1 in the next cycle.
    - Otherwise frame_err=1 in the next cycle, and data is unchanged.
    - Either way -> IDLE.
- Latency: valid/frame_err assert 1 cycle after the fall strobe of the stop bit. data is stable from the valid cycle until the next valid.
- Timeout:
  - In any non-IDLE state, the timeout counter increments every cycle and clears on fall.
  - On reaching TIMEOUT_CYCLES-1: frame_err pulse next cycle, FSM -> IDLE, no data update.
  - If fall and the timeout terminal count coincide in the same cycle, fall wins: the counter clears and the bit is processed.
  - The counter is held at 0 in IDLE.
- rx_en deasserted mid-frame: the current frame completes normally; only new start bits are gated.
- valid and frame_err are never high in the same cycle. Each pulses at most once per frame.
- Reset asserted mid-frame: immediate return to the reset state; the partial frame is discarded with no pulses.

Test Plan:
- Good frame: ps2_clk period 80 us with 50 MHz clk, sending byte 0x1C (bits 0,0,1,1,1,0,0,0; parity 0; stop 1) -> single valid pulse, data=8'h1C, frame_err never high, busy low after the stop bit.
- Parity error: 0x1C frame with parity=1 -> frame_err one-cycle pulse, valid stays 0, data keeps its previous value. A following 0xF0 frame (parity 1) -> valid, data=8'hF0.
- Stop error: 0x1C frame with stop bit 0 -> frame_err pulse, FSM back in IDLE (busy=0 one cycle after the pulse).
- Glitch rejection: ps2_clk low pulses of 5 cycles injected mid-frame and in IDLE with FILTER_CYCLES=16 -> no bit consumed; an unmodified frame 0x1C still yields data=8'h1C.
- Timeout and recovery: send start plus 4 data bits, then hold ps2_clk high -> frame_err exactly TIMEOUT_CYCLES (+-2 sync/filter cycles) after the last fall, busy=0. The next full 0x5A frame (parity 1) -> data=8'h5A.
- rx_en and reset: rx_en=0 at a start bit -> frame ignored, busy stays 0. rx_en dropped after the start bit -> frame still delivered. rst_n pulsed low mid-frame -> outputs at reset values, no valid/frame_err, next frame received correctly.
